// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes and
// datapath select values used by the controller and the ALU control decode.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_I_EXEC    = 4'd9,
    ST_I_WB      = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12,
    ST_JAL       = 4'd13,
    ST_JR        = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_OR    = 3'b011,
    ALU_AND   = 3'b100,
    ALU_LUI   = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RS     = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10
  } reg_dst_t;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_PC     = 2'b10
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_BRANCH = 2'b11
  } alu_src_b_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Unified instruction/data memory request handshake between sequencer and memory.
interface multicycle_control_if;
  logic mem_req_o;
  logic mem_write_o;
  logic mem_ready_i;

  modport master (output mem_req_o, output mem_write_o, input mem_ready_i);
  modport slave  (input mem_req_o, input mem_write_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: async active-low clear, wraps modulo 2^WIDTH.
module retire_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) count <= '0;
    else if (inc) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: drives datapath selects and the memory
// handshake, counts retired instructions and flags unknown opcodes.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode_i,
  input  logic [5:0]           funct_i,
  multicycle_control_if.master mem,
  output logic                 iord_o,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic                 branch_eq_o,
  output logic                 branch_ne_o,
  output logic [1:0]           pc_src_o,
  output logic                 reg_write_o,
  output logic [1:0]           reg_dst_o,
  output logic [1:0]           mem_to_reg_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic                 ext_zero_o,
  output logic [2:0]           alu_op_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] instr_count_o,
  output logic [3:0]           state_o
);

  state_t state, state_next;
  logic   mem_req, mem_write, retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    branch_eq_o  = 1'b0;
    branch_ne_o  = 1'b0;
    pc_src_o     = PC_ALU;
    reg_write_o  = 1'b0;
    reg_dst_o    = RD_RT;
    mem_to_reg_o = M2R_ALUOUT;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_B;
    ext_zero_o   = 1'b0;
    alu_op_o     = ALU_ADD;
    illegal_o    = 1'b0;

    case (state)
      ST_IDLE: state_next = ST_FETCH;

      // IR and PC+4 are committed only on the edge the memory completes.
      ST_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        if (mem.mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        alu_src_b_o = SRCB_BRANCH;
        case (opcode_i)
          OP_RTYPE:                       state_next = (funct_i == FN_JR) ? ST_JR : ST_R_EXEC;
          OP_LW, OP_SW:                   state_next = ST_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = ST_I_EXEC;
          OP_BEQ, OP_BNE:                 state_next = ST_BRANCH;
          OP_J:                           state_next = ST_JUMP;
          OP_JAL:                         state_next = ST_JAL;
          default: begin
            illegal_o  = 1'b1;
            state_next = ST_FETCH;
          end
        endcase
      end

      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        state_next  = (opcode_i == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      end

      ST_MEM_READ: begin
        mem_req = 1'b1;
        iord_o  = 1'b1;
        if (mem.mem_ready_i) state_next = ST_MEM_WB;
      end

      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
        state_next   = ST_FETCH;
      end

      ST_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord_o    = 1'b1;
        if (mem.mem_ready_i) state_next = ST_FETCH;
      end

      ST_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
        state_next  = ST_R_WB;
      end

      ST_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = RD_RD;
        state_next  = ST_FETCH;
      end

      ST_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        case (opcode_i)
          OP_ANDI: begin alu_op_o = ALU_AND; ext_zero_o = 1'b1; end
          OP_ORI:  begin alu_op_o = ALU_OR;  ext_zero_o = 1'b1; end
          OP_LUI:  alu_op_o = ALU_LUI;
          default: alu_op_o = ALU_ADD;
        endcase
        state_next = ST_I_WB;
      end

      ST_I_WB: begin
        reg_write_o = 1'b1;
        state_next  = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = PC_ALUOUT;
        branch_eq_o = (opcode_i == OP_BEQ);
        branch_ne_o = (opcode_i == OP_BNE);
        state_next  = ST_FETCH;
      end

      ST_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PC_JUMP;
        state_next = ST_FETCH;
      end

      // PC already holds PC+4, so $31 and the new PC share one edge.
      ST_JAL: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PC_JUMP;
        reg_write_o  = 1'b1;
        reg_dst_o    = RD_RA;
        mem_to_reg_o = M2R_PC;
        state_next   = ST_FETCH;
      end

      ST_JR: begin
        pc_write_o = 1'b1;
        pc_src_o   = PC_RS;
        state_next = ST_FETCH;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // Only completed instructions retire; IDLE start-up and illegal decode do not.
  assign retire = (state_next == ST_FETCH) &&
                  !(state inside {ST_IDLE, ST_FETCH, ST_DECODE});

  retire_counter #(.WIDTH(CNT_WIDTH)) u_retire_counter (
    .clk     (clk),
    .clear_n (reset),
    .inc     (retire),
    .count   (instr_count_o)
  );

  assign mem.mem_req_o   = mem_req;
  assign mem.mem_write_o = mem_write;
  assign state_o         = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus reset
// and counter-wrap sequences.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    state_t      st;
    ctrl_t       c;
    int unsigned cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct, op4;
  logic        iord, ir_write, pc_write, branch_eq, branch_ne, reg_write;
  logic        alu_src_a, ext_zero, illegal;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0]  alu_op;
  logic [31:0] count;
  logic [3:0]  state;

  logic        iord4, ir_write4, pc_write4, branch_eq4, branch_ne4, reg_write4;
  logic        alu_src_a4, ext_zero4, illegal4;
  logic [1:0]  pc_src4, reg_dst4, mem_to_reg4, alu_src_b4;
  logic [2:0]  alu_op4;
  logic [3:0]  count4;
  logic [3:0]  state4;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  vec_t        vecs[$];

  multicycle_control_if mif ();
  multicycle_control_if mif4 ();

  always #5 clk = ~clk;

  multicycle_control #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode), .funct_i(funct), .mem(mif.master),
    .iord_o(iord), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .branch_eq_o(branch_eq), .branch_ne_o(branch_ne), .pc_src_o(pc_src),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .ext_zero_o(ext_zero),
    .alu_op_o(alu_op), .illegal_o(illegal), .instr_count_o(count), .state_o(state)
  );

  multicycle_control #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .opcode_i(op4), .funct_i(6'h00), .mem(mif4.master),
    .iord_o(iord4), .ir_write_o(ir_write4), .pc_write_o(pc_write4),
    .branch_eq_o(branch_eq4), .branch_ne_o(branch_ne4), .pc_src_o(pc_src4),
    .reg_write_o(reg_write4), .reg_dst_o(reg_dst4), .mem_to_reg_o(mem_to_reg4),
    .alu_src_a_o(alu_src_a4), .alu_src_b_o(alu_src_b4), .ext_zero_o(ext_zero4),
    .alu_op_o(alu_op4), .illegal_o(illegal4), .instr_count_o(count4), .state_o(state4)
  );

  function automatic ctrl_t actual();
    ctrl_t c;
    c = '{mif.mem_req_o, mif.mem_write_o, iord, ir_write, pc_write, branch_eq, branch_ne,
          pc_src, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op, illegal};
    return c;
  endfunction

  function automatic ctrl_t c_fetch(logic rdy);
    ctrl_t c = '0;
    c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic ctrl_t c_decode(logic ill);
    ctrl_t c = '0;
    c.alu_src_b = 2'b11; c.illegal = ill;
    return c;
  endfunction
  function automatic ctrl_t c_memaddr();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctrl_t c_mem(logic wr);
    ctrl_t c = '0;
    c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = wr;
    return c;
  endfunction
  function automatic ctrl_t c_wb(logic [1:0] dst, logic [1:0] m2r);
    ctrl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = dst; c.mem_to_reg = m2r;
    return c;
  endfunction
  function automatic ctrl_t c_rexec();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b010;
    return c;
  endfunction
  function automatic ctrl_t c_iexec(logic [2:0] aop, logic ext);
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = aop; c.ext_zero = ext;
    return c;
  endfunction
  function automatic ctrl_t c_branch(logic eq, logic ne);
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_src = 2'b01; c.branch_eq = eq; c.branch_ne = ne;
    return c;
  endfunction
  function automatic ctrl_t c_pcw(logic [1:0] src);
    ctrl_t c = '0;
    c.pc_write = 1'b1; c.pc_src = src;
    return c;
  endfunction
  function automatic ctrl_t c_jal();
    ctrl_t c = '0;
    c.pc_write = 1'b1; c.pc_src = 2'b10; c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
    return c;
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                     input state_t st, input ctrl_t c, input int unsigned cnt);
    vecs.push_back('{op, fn, rdy, st, c, cnt});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; opcode = '0; funct = '0; op4 = 6'h02;
    mif.mem_ready_i = 1'b1; mif4.mem_ready_i = 1'b1;

    // add: zero wait, 4 cycles from FETCH
    add(6'h00, 6'h20, 1'b1, ST_IDLE,      '0,                  0);
    add(6'h00, 6'h20, 1'b1, ST_FETCH,     c_fetch(1'b1),       0);
    add(6'h00, 6'h20, 1'b1, ST_DECODE,    c_decode(1'b0),      0);
    add(6'h00, 6'h20, 1'b1, ST_R_EXEC,    c_rexec(),           0);
    add(6'h00, 6'h20, 1'b1, ST_R_WB,      c_wb(2'b01, 2'b00),  0);
    // lw: three wait cycles in MEM_READ
    add(6'h23, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       1);
    add(6'h23, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      1);
    add(6'h23, 6'h00, 1'b1, ST_MEM_ADDR,  c_memaddr(),         1);
    add(6'h23, 6'h00, 1'b0, ST_MEM_READ,  c_mem(1'b0),         1);
    add(6'h23, 6'h00, 1'b0, ST_MEM_READ,  c_mem(1'b0),         1);
    add(6'h23, 6'h00, 1'b0, ST_MEM_READ,  c_mem(1'b0),         1);
    add(6'h23, 6'h00, 1'b1, ST_MEM_READ,  c_mem(1'b0),         1);
    add(6'h23, 6'h00, 1'b1, ST_MEM_WB,    c_wb(2'b00, 2'b01),  1);
    // sw: one wait in FETCH, one in MEM_WRITE
    add(6'h2B, 6'h00, 1'b0, ST_FETCH,     c_fetch(1'b0),       2);
    add(6'h2B, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       2);
    add(6'h2B, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      2);
    add(6'h2B, 6'h00, 1'b1, ST_MEM_ADDR,  c_memaddr(),         2);
    add(6'h2B, 6'h00, 1'b0, ST_MEM_WRITE, c_mem(1'b1),         2);
    add(6'h2B, 6'h00, 1'b1, ST_MEM_WRITE, c_mem(1'b1),         2);
    // ori with mem_ready low where it must be ignored
    add(6'h0D, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       3);
    add(6'h0D, 6'h00, 1'b0, ST_DECODE,    c_decode(1'b0),      3);
    add(6'h0D, 6'h00, 1'b0, ST_I_EXEC,    c_iexec(3'b011, 1),  3);
    add(6'h0D, 6'h00, 1'b0, ST_I_WB,      c_wb(2'b00, 2'b00),  3);
    add(6'h0C, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       4);
    add(6'h0C, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      4);
    add(6'h0C, 6'h00, 1'b1, ST_I_EXEC,    c_iexec(3'b100, 1),  4);
    add(6'h0C, 6'h00, 1'b1, ST_I_WB,      c_wb(2'b00, 2'b00),  4);
    add(6'h0F, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       5);
    add(6'h0F, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      5);
    add(6'h0F, 6'h00, 1'b1, ST_I_EXEC,    c_iexec(3'b101, 0),  5);
    add(6'h0F, 6'h00, 1'b1, ST_I_WB,      c_wb(2'b00, 2'b00),  5);
    add(6'h08, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       6);
    add(6'h08, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      6);
    add(6'h08, 6'h00, 1'b1, ST_I_EXEC,    c_iexec(3'b000, 0),  6);
    add(6'h08, 6'h00, 1'b1, ST_I_WB,      c_wb(2'b00, 2'b00),  6);
    // control transfers: 3 cycles each
    add(6'h04, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       7);
    add(6'h04, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      7);
    add(6'h04, 6'h00, 1'b1, ST_BRANCH,    c_branch(1, 0),      7);
    add(6'h05, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       8);
    add(6'h05, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      8);
    add(6'h05, 6'h00, 1'b1, ST_BRANCH,    c_branch(0, 1),      8);
    add(6'h02, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       9);
    add(6'h02, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      9);
    add(6'h02, 6'h00, 1'b1, ST_JUMP,      c_pcw(2'b10),        9);
    add(6'h03, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       10);
    add(6'h03, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b0),      10);
    add(6'h03, 6'h00, 1'b1, ST_JAL,       c_jal(),             10);
    add(6'h00, 6'h08, 1'b1, ST_FETCH,     c_fetch(1'b1),       11);
    add(6'h00, 6'h08, 1'b1, ST_DECODE,    c_decode(1'b0),      11);
    add(6'h00, 6'h08, 1'b1, ST_JR,        c_pcw(2'b11),        11);
    // illegal opcode: one-cycle pulse, not retired
    add(6'h3F, 6'h00, 1'b1, ST_FETCH,     c_fetch(1'b1),       12);
    add(6'h3F, 6'h00, 1'b1, ST_DECODE,    c_decode(1'b1),      12);
    add(6'h00, 6'h20, 1'b1, ST_FETCH,     c_fetch(1'b1),       12);
    add(6'h00, 6'h20, 1'b1, ST_DECODE,    c_decode(1'b0),      12);
    add(6'h00, 6'h20, 1'b1, ST_R_EXEC,    c_rexec(),           12);
    add(6'h00, 6'h20, 1'b1, ST_R_WB,      c_wb(2'b01, 2'b00),  12);
    add(6'h00, 6'h20, 1'b0, ST_FETCH,     c_fetch(1'b0),       13);

    #2;
    check("reset state", 32'(state), 32'(ST_IDLE));
    check("reset ctrl",  32'(actual()), 32'h0);
    check("reset count", count, 32'h0);
    @(posedge clk); #1;
    check("reset held ctrl", 32'(actual()), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op; funct = vecs[i].fn; mif.mem_ready_i = vecs[i].rdy;
      #2;
      check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("v%0d ctrl", i), 32'(actual()), 32'(vecs[i].c));
      check($sformatf("v%0d count", i), count, vecs[i].cnt);
      @(posedge clk); #1;
    end

    // reset during a FETCH wait drops the request without a clock edge
    mif.mem_ready_i = 1'b0;
    #2;
    check("wait req", 32'(mif.mem_req_o), 32'h1);
    reset = 1'b0;
    #1;
    check("async req", 32'(mif.mem_req_o), 32'h0);
    check("async state", 32'(state), 32'(ST_IDLE));
    check("async count", count, 32'h0);
    check("async ctrl", 32'(actual()), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 4-bit counter retiring jumps: one retire every 3 cycles after IDLE
    repeat (46) @(posedge clk);
    #1;
    check("wrap count15", 32'(count4), 32'hF);
    repeat (3) @(posedge clk);
    #1;
    check("wrap count0", 32'(count4), 32'h0);
    check("wrap state", 32'(state4), 32'(ST_FETCH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
